// File: rtl/reset_sequencer.sv
// reset_sequencer: debounces pll_locked on clk_in, then releases NTSC, USB and core resets in turn.
// Rev 1.0
`default_nettype none

module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 64
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       rst_ntsc_n,
  output logic       rst_usb_n,
  output logic       rst_core_n,
  output logic       seq_done,
  output logic [2:0] seq_state,
  output logic [7:0] lock_lost_cnt
);

  localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                              LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    STAGE1    = 3'd2,
    STAGE2    = 3'd3,
    RUN       = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, lock_s_q;
  logic             ntsc_q, ntsc_d;
  logic             usb_q, usb_d;
  logic             core_q, core_d;
  logic             done_q, done_d;
  logic [7:0]       lost_q, lost_d;
  logic             abort, count_loss;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ntsc_d     = ntsc_q;
    usb_d      = usb_q;
    core_d     = core_q;
    done_d     = done_q;
    lost_d     = lost_q;
    abort      = 1'b0;
    count_loss = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        ntsc_d  = 1'b0;
        usb_d   = 1'b0;
        core_d  = 1'b0;
        done_d  = 1'b0;
      end
      WAIT_LOCK: begin
        if (!lock_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = STAGE1;
          ntsc_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STAGE1: begin
        if (!lock_s_q) begin
          abort      = 1'b1;
          count_loss = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = STAGE2;
          usb_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STAGE2: begin
        if (!lock_s_q) begin
          abort      = 1'b1;
          count_loss = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          core_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        // Lock loss is checked first so a coincident soft request counts once.
        if (!lock_s_q) begin
          abort      = 1'b1;
          count_loss = 1'b1;
        end else if (soft_rst_req) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ntsc_d  = 1'b0;
        usb_d   = 1'b0;
        core_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    if (abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      ntsc_d  = 1'b0;
      usb_d   = 1'b0;
      core_d  = 1'b0;
      done_d  = 1'b0;
      if (count_loss && (lost_q != 8'hFF)) begin
        lost_d = lost_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      ntsc_q   <= 1'b0;
      usb_q    <= 1'b0;
      core_q   <= 1'b0;
      done_q   <= 1'b0;
      lost_q   <= 8'd0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ntsc_q   <= ntsc_d;
      usb_q    <= usb_d;
      core_q   <= core_d;
      done_q   <= done_d;
      lost_q   <= lost_d;
    end
  end

  assign rst_ntsc_n    = ntsc_q;
  assign rst_usb_n     = usb_q;
  assign rst_core_n    = core_q;
  assign seq_done      = done_q;
  assign seq_state     = state_q;
  assign lock_lost_cnt = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench; expected output vectors are queued with the cycle they are due.
// Rev 1.0
`default_nettype none

module tb_reset_sequencer;

  localparam int LSC = 16;
  localparam int SGC = 4;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       rst_ntsc_n, rst_usb_n, rst_core_n, seq_done;
  logic [2:0] seq_state;
  logic [7:0] lock_lost_cnt;
  logic [14:0] obs;

  typedef struct {
    string       tag;
    int          at;
    logic [14:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   base;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP_CYCLES  (SGC)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .rst_ntsc_n   (rst_ntsc_n),
    .rst_usb_n    (rst_usb_n),
    .rst_core_n   (rst_core_n),
    .seq_done     (seq_done),
    .seq_state    (seq_state),
    .lock_lost_cnt(lock_lost_cnt)
  );

  assign obs = {rst_ntsc_n, rst_usb_n, rst_core_n, seq_done, seq_state, lock_lost_cnt};

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got ntsc/usb/core/done=%b state=%0d lost=%0d, want ntsc/usb/core/done=%b state=%0d lost=%0d",
               tag, got[14:11], got[10:8], got[7:0], want[14:11], want[10:8], want[7:0]);
    end
  endtask

  function automatic logic [14:0] ev(input logic ntsc, input logic usb, input logic core,
                                     input logic done, input logic [2:0] st, input logic [7:0] lost);
    return {ntsc, usb, core, done, st, lost};
  endfunction

  task automatic put(input string tag, input int off, input logic [14:0] v);
    exp_t e;
    e.tag = tag;
    e.at  = cyc + off;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  // Asserts rst_n mid-cycle, checks the asynchronous reset values, then releases.
  task automatic restart(input string tag);
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    rst_n        = 1'b0;
    put(tag, 0, ev(0, 0, 0, 0, 3'd0, 8'd0));
    tick(2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, obs, mon_e.v);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    tick(1);

    // Nominal: lock raised after the IDLE edge, releases at 19/23/27.
    restart("reset_state");
    base = cyc;
    put("idle_to_wait", 1,  ev(0, 0, 0, 0, 3'd1, 8'd0));
    put("ntsc_pre",     18, ev(0, 0, 0, 0, 3'd1, 8'd0));
    put("ntsc_rise",    19, ev(1, 0, 0, 0, 3'd2, 8'd0));
    put("usb_pre",      22, ev(1, 0, 0, 0, 3'd2, 8'd0));
    put("usb_rise",     23, ev(1, 1, 0, 0, 3'd3, 8'd0));
    put("core_pre",     26, ev(1, 1, 0, 0, 3'd3, 8'd0));
    put("core_rise",    27, ev(1, 1, 1, 1, 3'd4, 8'd0));
    tick(1);
    pll_locked = 1'b1;
    goto_cyc(base + 30);

    // Glitchy lock: one low cycle restarts the debounce count.
    restart("reset_b");
    base = cyc;
    put("glitch_clr",   14, ev(0, 0, 0, 0, 3'd1, 8'd0));
    put("glitch_hold",  19, ev(0, 0, 0, 0, 3'd1, 8'd0));
    put("glitch_pre",   29, ev(0, 0, 0, 0, 3'd1, 8'd0));
    put("glitch_ntsc",  30, ev(1, 0, 0, 0, 3'd2, 8'd0));
    put("glitch_run",   38, ev(1, 1, 1, 1, 3'd4, 8'd0));
    tick(1);
    pll_locked = 1'b1;
    goto_cyc(base + 11);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    goto_cyc(base + 40);

    // Lock loss in RUN, then full re-sequence.
    base = cyc;
    put("loss_hold",    2,  ev(1, 1, 1, 1, 3'd4, 8'd0));
    put("loss_drop",    3,  ev(0, 0, 0, 0, 3'd1, 8'd1));
    put("relock_pre",   20, ev(0, 0, 0, 0, 3'd1, 8'd1));
    put("relock_ntsc",  21, ev(1, 0, 0, 0, 3'd2, 8'd1));
    put("relock_run",   29, ev(1, 1, 1, 1, 3'd4, 8'd1));
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    goto_cyc(base + 32);

    // Soft reset in RUN; a second pulse during STAGE1 must be ignored.
    base = cyc;
    put("soft_drop",    1,  ev(0, 0, 0, 0, 3'd1, 8'd1));
    put("soft_ntsc",    17, ev(1, 0, 0, 0, 3'd2, 8'd1));
    put("soft_ign_usb", 21, ev(1, 1, 0, 0, 3'd3, 8'd1));
    put("soft_run",     25, ev(1, 1, 1, 1, 3'd4, 8'd1));
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    goto_cyc(base + 18);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    goto_cyc(base + 28);

    // Soft request on the same edge that sees lock_s low: one increment.
    base = cyc;
    put("both_drop",    3,  ev(0, 0, 0, 0, 3'd1, 8'd2));
    put("both_once",    4,  ev(0, 0, 0, 0, 3'd1, 8'd2));
    put("both_run",     29, ev(1, 1, 1, 1, 3'd4, 8'd2));
    pll_locked = 1'b0;
    tick(2);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    pll_locked   = 1'b1;
    goto_cyc(base + 32);

    // Saturation: one loss in RUN, then 300 losses during STAGE1.
    put("run_loss", 3, ev(0, 0, 0, 0, 3'd1, 8'd3));
    pll_locked = 1'b0;
    tick(3);
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      tick(18);
      if (i == 0 || i == 251 || i == 299)
        put($sformatf("sat_stage1_%0d", i), 0,
            ev(1, 0, 0, 0, 3'd2, 8'((3 + i > 255) ? 255 : 3 + i)));
      pll_locked = 1'b0;
      tick(3);
      if (i == 0 || i == 250 || i == 251 || i == 252 || i == 299)
        put($sformatf("sat_loss_%0d", i), 0,
            ev(0, 0, 0, 0, 3'd1, 8'((4 + i > 255) ? 255 : 4 + i)));
    end

    // rst_n asserted in STAGE2 clears everything, including the loss count.
    pll_locked = 1'b1;
    tick(22);
    put("stage2_pre_rst", 0, ev(1, 1, 0, 0, 3'd3, 8'd255));
    tick(1);
    restart("mid_rst");
    put("post_rst", 1, ev(0, 0, 0, 0, 3'd1, 8'd0));
    tick(3);

    tick(2);
    chk("sb_empty", 15'(sb.size()), 15'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
